// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, IF/ID register with
// a one-entry skid buffer for stalls, and redirect with in-flight drain.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode
);

  // state | meaning
  // IDLE  | out of reset, no request yet
  // WAIT  | request at pc outstanding
  // HOLD  | response parked in skid while decode stalls
  // DRAIN | stale response in flight after redirect, drop it
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] skid_instr, skid_instr_n;
  logic [31:0] skid_pc, skid_pc_n;
  logic        id_valid_n;
  logic [31:0] id_instr_n, id_pc_n;
  logic [6:0]  id_opcode_n;

  assign imem_req  = (state == WAIT);
  assign imem_addr = pc;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    id_valid_n   = id_valid;
    id_instr_n   = id_instr;
    id_pc_n      = id_pc;
    id_opcode_n  = id_opcode;

    if (redirect) begin
      pc_n         = redirect_pc & ~32'h3;
      id_valid_n   = 1'b0;
      id_instr_n   = NOP_INSTR;
      id_opcode_n  = NOP_INSTR[6:0];
      skid_instr_n = NOP_INSTR;
      skid_pc_n    = '0;
      unique case (state)
        IDLE:    state_n = WAIT;
        WAIT:    state_n = imem_rvalid ? WAIT : DRAIN;
        HOLD:    state_n = WAIT;
        DRAIN:   state_n = DRAIN;
        default: state_n = IDLE;
      endcase
    end else begin
      // bubble by default when decode is free; overridden below on a load
      if (!stall) begin
        id_valid_n  = 1'b0;
        id_instr_n  = NOP_INSTR;
        id_opcode_n = NOP_INSTR[6:0];
      end
      unique case (state)
        IDLE: state_n = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            pc_n = pc + 32'd4;
            if (stall) begin
              skid_instr_n = imem_rdata;
              skid_pc_n    = pc;
              state_n      = HOLD;
            end else begin
              id_valid_n  = 1'b1;
              id_instr_n  = imem_rdata;
              id_pc_n     = pc;
              id_opcode_n = imem_rdata[6:0];
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            id_valid_n  = 1'b1;
            id_instr_n  = skid_instr;
            id_pc_n     = skid_pc;
            id_opcode_n = skid_instr[6:0];
            state_n     = WAIT;
          end
        end
        DRAIN: begin
          if (imem_rvalid) state_n = WAIT;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      skid_instr <= NOP_INSTR;
      skid_pc    <= '0;
      id_valid   <= 1'b0;
      id_instr   <= NOP_INSTR;
      id_pc      <= '0;
      id_opcode  <= 7'b0010011;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
      id_valid   <= id_valid_n;
      id_instr   <= id_instr_n;
      id_pc      <= id_pc_n;
      id_opcode  <= id_opcode_n;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall/skid, redirect,
// pc wrap, reset in HOLD and back-to-back responses.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_opcode(id_opcode)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    checks++;
    if (id_valid !== 1'b0 || id_instr !== 32'h13 || id_pc !== 32'h0 || id_opcode !== 7'b0010011) begin
      errors++;
      $display("FAIL reset_ifid: valid=%b instr=%h pc=%h op=%b, want 0 00000013 00000000 0010011",
               id_valid, id_instr, id_pc, id_opcode);
    end
    checks++;
    if (imem_req !== 1'b0 || dut.state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: req=%b state=%0d, want req=0 state=0", imem_req, dut.state);
    end
    reset = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_first_req: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4)) begin
        errors++;
        $display("FAIL seq_addr[%0d]: req=%b addr=%h, want 1 %h", i, imem_req, imem_addr, 32'(i * 4));
      end
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0000_0033;
      step();
      imem_rvalid = 1'b0;
      checks++;
      if (id_valid !== 1'b1 || id_instr !== 32'h33 || id_pc !== 32'(i * 4) || id_opcode !== 7'b0110011) begin
        errors++;
        $display("FAIL seq_load[%0d]: valid=%b instr=%h pc=%h op=%b, want 1 00000033 %h 0110011",
                 i, id_valid, id_instr, id_pc, id_opcode, 32'(i * 4));
      end
    end
  endtask

  // Fresh reset, fetch 0x0 and 0x4, then stall across the response at 0x8
  task automatic test_stall();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0000_0033;
      step();
    end
    checks++;
    if (imem_addr !== 32'h8 || id_pc !== 32'h4 || id_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_setup: addr=%h id_pc=%h valid=%b, want 00000008 00000004 1", imem_addr, id_pc, id_valid);
    end
    stall       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_2003;
    for (int c = 0; c < 3; c++) begin
      step();
      imem_rvalid = (c == 0);
      imem_rdata  = 32'hDEAD_BEEF;
      checks++;
      if (dut.state !== 2'd2 || imem_req !== 1'b0 || id_valid !== 1'b1 ||
          id_instr !== 32'h33 || id_pc !== 32'h4 || id_opcode !== 7'b0110011) begin
        errors++;
        $display("FAIL stall_hold[%0d]: state=%0d req=%b valid=%b instr=%h pc=%h op=%b, want 2 0 1 00000033 00000004 0110011",
                 c, dut.state, imem_req, id_valid, id_instr, id_pc, id_opcode);
      end
    end
    stall       = 1'b0;
    imem_rvalid = 1'b0;
    step();
    checks++;
    if (id_valid !== 1'b1 || id_instr !== 32'h2003 || id_pc !== 32'h8 || id_opcode !== 7'b0000011) begin
      errors++;
      $display("FAIL stall_release: valid=%b instr=%h pc=%h op=%b, want 1 00002003 00000008 0000011",
               id_valid, id_instr, id_pc, id_opcode);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      errors++;
      $display("FAIL stall_next_req: req=%b addr=%h, want 1 0000000c", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_drain();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    checks++;
    if (dut.state !== 2'd3 || imem_req !== 1'b0 || id_valid !== 1'b0 || id_instr !== 32'h13) begin
      errors++;
      $display("FAIL drain_enter: state=%0d req=%b valid=%b instr=%h, want 3 0 0 00000013",
               dut.state, imem_req, id_valid, id_instr);
    end
    step();
    checks++;
    if (dut.state !== 2'd3 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_wait: state=%0d valid=%b, want 3 0", dut.state, id_valid);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0033;
    step();
    imem_rvalid = 1'b0;
    checks++;
    if (dut.state !== 2'd1 || imem_req !== 1'b1 || imem_addr !== 32'h100 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_exit: state=%0d req=%b addr=%h valid=%b, want 1 1 00000100 0",
               dut.state, imem_req, imem_addr, id_valid);
    end
  endtask

  task automatic test_redirect_rvalid_stall();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_2003;
    stall       = 1'b1;
    step();
    clear_inputs();
    checks++;
    if (dut.state !== 2'd1 || imem_addr !== 32'h200 || id_valid !== 1'b0 || id_instr !== 32'h13) begin
      errors++;
      $display("FAIL redir_same_cycle: state=%0d addr=%h valid=%b instr=%h, want 1 00000200 0 00000013",
               dut.state, imem_addr, id_valid, id_instr);
    end
  endtask

  task automatic test_wrap();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0013;
    step();
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL wrap_setup: addr=%h req=%b, want fffffffc 1", imem_addr, imem_req);
    end
    imem_rdata = 32'h0000_0033;
    step();
    imem_rvalid = 1'b0;
    checks++;
    if (imem_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC || id_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap: addr=%h id_pc=%h valid=%b, want 00000000 fffffffc 1", imem_addr, id_pc, id_valid);
    end
  endtask

  task automatic test_reset_in_hold();
    stall       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_2003;
    step();
    imem_rvalid = 1'b0;
    checks++;
    if (dut.state !== 2'd2 || id_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_hold_setup: state=%0d valid=%b, want 2 1", dut.state, id_valid);
    end
    reset = 1'b1;
    step();
    checks++;
    if (dut.state !== 2'd0 || id_valid !== 1'b0 || id_instr !== 32'h13 || id_pc !== 32'h0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold: state=%0d valid=%b instr=%h pc=%h req=%b, want 0 0 00000013 00000000 0",
               dut.state, id_valid, id_instr, id_pc, imem_req);
    end
    reset = 1'b0;
    stall = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_hold_req: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0033;
    step();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL b2b_first: valid=%b id_pc=%h addr=%h, want 1 00000000 00000004", id_valid, id_pc, imem_addr);
    end
    imem_rdata = 32'h0010_0093;
    step();
    imem_rvalid = 1'b0;
    checks++;
    if (id_valid !== 1'b1 || id_instr !== 32'h0010_0093 || id_pc !== 32'h4 ||
        id_opcode !== 7'b0010011 || imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL b2b_second: valid=%b instr=%h pc=%h op=%b addr=%h, want 1 00100093 00000004 0010011 00000008",
               id_valid, id_instr, id_pc, id_opcode, imem_addr);
    end
    step();
    checks++;
    if (id_valid !== 1'b0 || id_instr !== 32'h13 || imem_addr !== 32'h8 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL b2b_bubble: valid=%b instr=%h addr=%h req=%b, want 0 00000013 00000008 1",
               id_valid, id_instr, imem_addr, imem_req);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_drain();
    test_redirect_rvalid_stall();
    test_wrap();
    test_reset_in_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
